// File: rtl/cic_integ_decim.sv
// ============================================================================
//  Module   : cic_integ_decim
//  Brief    : CIC integrator cascade with decimate-by-R output register/strobe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_integ_decim #(
    parameter int IN_W  = 9,
    parameter int ACC_W = 22,
    parameter int N     = 3,
    parameter int R     = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic [IN_W-1:0]  data_i,
    output logic             en_o,
    output logic [ACC_W-1:0] data_o
);

    localparam int CNT_W = $clog2(R);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(R - 1);

    logic [ACC_W-1:0] w_sext;
    logic [ACC_W-1:0] w_stage_in [N];
    logic [ACC_W-1:0] r_int      [N];
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_last;
    logic             w_load;
    logic             r_en_o;
    logic [ACC_W-1:0] r_data;

    assign w_sext = {{(ACC_W - IN_W){data_i[IN_W-1]}}, data_i};

    // Each stage adds the previous stage's registered value, so the chain
    // has one adder per stage and N cycles of pipeline latency.
    generate
        for (genvar k = 0; k < N; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign w_stage_in[k] = w_sext;
            end else begin : g_next
                assign w_stage_in[k] = r_int[k-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < N; k++) begin
                r_int[k] <= '0;
            end
        end else if (en_i) begin
            for (int k = 0; k < N; k++) begin
                r_int[k] <= r_int[k] + w_stage_in[k];
            end
        end
    end

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign w_load     = en_i & w_cnt_last;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // The strobe is a single cycle: it is cleared on every edge without a load.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_en_o <= 1'b0;
            r_data <= '0;
        end else begin
            r_en_o <= w_load;
            if (w_load) begin
                r_data <= r_int[N-1];
            end
        end
    end

    assign en_o   = r_en_o;
    assign data_o = r_data;

endmodule

`default_nettype wire

// File: tb/tb_cic_integ_decim.sv
// ============================================================================
//  Module   : tb_cic_integ_decim
//  Brief    : Self-checking bench for cic_integ_decim (closed-form CIC model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cic_integ_decim;

    localparam int IN_W  = 9;
    localparam int ACC_W = 22;
    localparam int N     = 3;
    localparam int R     = 4;
    localparam int D     = 5;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic             en_i;
    logic [IN_W-1:0]  data_i;
    logic             en_o;
    logic [ACC_W-1:0] data_o;

    int total = 0;
    int bad   = 0;

    longint hist[$];
    longint strobes[$];
    longint last_data;
    bit     cascade_on;
    longint cd [3][D];
    int     comb_cnt;

    cic_integ_decim #(.IN_W(IN_W), .ACC_W(ACC_W), .N(N), .R(R)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (en_i),
        .data_i (data_i),
        .en_o   (en_o),
        .data_o (data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap(input longint v);
        logic signed [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return longint'(t);
    endfunction

    function automatic longint binom(input longint m, input int k);
        longint r;
        if (m < k) return 0;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (m - i) / (i + 1);
        return r;
    endfunction

    // N-fold running sum seen N samples late: y(n) = sum_j x(j) * C(n-1-j, N-1).
    function automatic longint model(input int n);
        longint s;
        s = 0;
        for (int j = 0; j < n; j++) s += hist[j] * binom(longint'(n - 1 - j), N - 1);
        return wrap(s);
    endfunction

    function automatic longint comb_push(input longint x_in);
        longint x, y;
        x = x_in;
        for (int s = 0; s < 3; s++) begin
            y = x - cd[s][D-1];
            for (int i = D - 1; i > 0; i--) cd[s][i] = cd[s][i-1];
            cd[s][0] = x;
            x = wrap(y);
        end
        return x;
    endfunction

    task automatic step(input logic en, input logic [IN_W-1:0] d);
        logic   exp_en;
        longint exp_d, y;
        @(negedge clk_i);
        en_i   = en;
        data_i = d;
        @(posedge clk_i);
        #1;
        if (en) hist.push_back(longint'($signed(d)));
        exp_en = en && (hist.size() % R == 0);
        exp_d  = exp_en ? model(hist.size() - 1) : last_data;
        last_data = exp_d;
        check("en_o", longint'(en_o), longint'(exp_en));
        check("data_o", longint'($signed(data_o)), exp_d);
        if ($isunknown({en_o, data_o})) check("no_x", 1, 0);
        if (en_o === 1'b1) begin
            strobes.push_back(longint'($signed(data_o)));
            if (cascade_on) begin
                y = comb_push(longint'($signed(data_o)));
                comb_cnt++;
                if (comb_cnt > 20) check("cascade_dc", y, 8000);
            end
        end
    endtask

    task automatic do_reset(input bit check_async);
        @(posedge clk_i);
        #2;
        rstn_i = 1'b0;
        en_i   = 1'b1;
        data_i = IN_W'(77);
        #1;
        if (check_async) begin
            check("async_rst_en_o", longint'(en_o), 0);
            check("async_rst_data_o", longint'($signed(data_o)), 0);
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        en_i   = 1'b0;
        hist.delete();
        strobes.delete();
        last_data = 0;
    endtask

    task automatic check_three(input string name, input longint e0, input longint e1,
                               input longint e2);
        check({name, "_count"}, longint'(strobes.size()), 3);
        if (strobes.size() >= 3) begin
            check({name, "_s0"}, strobes[0], e0);
            check({name, "_s1"}, strobes[1], e1);
            check({name, "_s2"}, strobes[2], e2);
        end
    endtask

    typedef struct {
        string                  name;
        int                     gap;
        logic [IN_W-1:0]        first;
        logic [IN_W-1:0]        rest;
        longint                 e0;
        longint                 e1;
        longint                 e2;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{"impulse",      1, 9'd1,   9'd0,   1,  15,   45};
        tbl[1] = '{"impulse_gap3", 3, 9'd1,   9'd0,   1,  15,   45};
        tbl[2] = '{"neg_dc",       1, 9'h1FF, 9'h1FF, -1, -35, -165};
        tbl[3] = '{"neg_dc_gap2",  2, 9'h1FF, 9'h1FF, -1, -35, -165};
        tbl[4] = '{"pos_dc",       1, 9'd1,   9'd1,   1,  35,  165};

        cascade_on = 1'b0;
        comb_cnt   = 0;
        last_data  = 0;
        rstn_i     = 1'b0;
        en_i       = 1'b0;
        data_i     = '0;
        #3;
        check("reset_en_o", longint'(en_o), 0);
        check("reset_data_o", longint'($signed(data_o)), 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;

        for (int t = 0; t < 5; t++) begin
            do_reset(1'b0);
            for (int i = 0; i < 12; i++) begin
                for (int g = 1; g < tbl[t].gap; g++) step(1'b0, '0);
                step(1'b1, (i == 0) ? tbl[t].first : tbl[t].rest);
            end
            check_three(tbl[t].name, tbl[t].e0, tbl[t].e1, tbl[t].e2);
        end

        // Mid-run reset: partial count and non-zero output must be discarded.
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, IN_W'(100));
        check("prerst_data_o", longint'($signed(data_o)), 100);
        do_reset(1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, (i == 0) ? IN_W'(1) : IN_W'(0));
        check_three("rst_impulse", 1, 15, 45);

        // Long positive DC forces integrator wrap-around.
        do_reset(1'b0);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, IN_W'($urandom));
            step(1'b1, IN_W'(255));
        end
        check("wrap_strobes", longint'(strobes.size()), 250);

        do_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, IN_W'($urandom));
            step(1'b1, IN_W'($urandom));
        end
        check("rand_strobes", longint'(strobes.size()), 100);

        do_reset(1'b0);
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < D; i++) cd[s][i] = 0;
        cascade_on = 1'b1;
        comb_cnt   = 0;
        for (int i = 0; i < 200; i++) step(1'b1, IN_W'(1));
        cascade_on = 1'b0;
        check("cascade_strobes", longint'(comb_cnt), 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
